can_form_checker: RTL
=====================

# can_form_checker

Parametrised CAN form-error checker, successor to the single-bit delimiter check in the bit-stream decoder. It runs on the system clock and samples `rx` only on the `sp` (sample point) strobe. It checks every fixed-form field: CRC delimiter, ACK delimiter, End-Of-Frame and error/overload delimiter. It reports each violation with field code and bit position, raises an overload request for a dominant last EOF bit in receiver mode, and keeps a saturating error count for the error-management block.

## Interface
Parameters:
- `EOF_LEN`, 7, number of recessive EOF bits checked.
- `DELIM_LEN`, 8, number of recessive error/overload delimiter bits checked.
- `RX_MODE`, 1, 1 = receiver (dominant last EOF bit is an overload request, not an error); 0 = transmitter (all EOF bits checked).
- `STICKY`, 0, 1 = `FORM_Error` held low until `clear`; 0 = re-evaluated every sample point.
- `CNT_W`, 8, width of `err_count`.

Ports:
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; all state and outputs to reset values while low.
- `sp` in 1: sample-point strobe, one `clock` cycle wide.
- `RX` in 1: bus bit, 1 = recessive.
- `F_CRC_D` in 1: active-low, current bit is the CRC delimiter.
- `F_ACK_D` in 1: active-low, current bit is the ACK delimiter.
- `F_EOF` in 1: active-low, held low for the whole EOF field.
- `F_ERR_D` in 1: active-low, held low for the whole error/overload delimiter.
- `clear` in 1: synchronous, clears the sticky error and `err_count`.
- `FORM_Error` out 1: active-low form-error flag.
- `err_field` out 3: field code of the last error (see package).
- `err_pos` out 4: bit index within the field of the last error.
- `overload_req` out 1: one-cycle pulse, receiver mode only.
- `err_count` out CNT_W: saturating count of form errors.

## Operation
- FSM states: IDLE, EOF, DELIM. Only a `sp` cycle can change state or update the error outputs.
- Field priority when several flags are low on the same `sp`: ACK_D > CRC_D > EOF > ERR_D. Only the highest-priority field is checked.
- CRC_D or ACK_D low on `sp`: checked in any state. `RX`=0 is an error with `err_pos`=0. These flags do not change FSM state.
- EOF:
  - `F_EOF` low on `sp` from IDLE: enter EOF, bit counter = 0, check the bit.
  - Each further `sp` with `F_EOF` low increments the counter and checks `RX`.
  - Counter saturates at EOF_LEN; bits at index ≥ EOF_LEN are not checked.
- Last EOF bit (index EOF_LEN-1) dominant:
  - RX_MODE=1: pulse `overload_req`, no error.
  - RX_MODE=0: form error.
- DELIM: same counting scheme with `F_ERR_D` and DELIM_LEN; every bit index < DELIM_LEN is checked.
- Flag deasserted on `sp` while in EOF or DELIM: return to IDLE, counter = 0 (field aborted, no error).
- Flag switches directly from EOF to ERR_D: go to DELIM with counter 0.
- On error:
  - `FORM_Error` driven low.
  - `err_field` and `err_pos` loaded.
  - `err_count` incremented, saturating at all-ones.
- STICKY=0: each `sp` with no error returns `FORM_Error` to 1. `err_field` and `err_pos` keep their last value.
- STICKY=1: `FORM_Error` stays 0 until `clear`.
- `clear` and an error on the same cycle: the error wins, `err_count` = 1.
- Reset values: `FORM_Error`=1, `err_field`=NONE, `err_pos`=0, `overload_req`=0, `err_count`=0, FSM=IDLE, counter=0.

## Timing
- Latency: outputs update on the `clock` edge that samples `sp`=1 and are visible the next cycle.
- `overload_req` is high for exactly that one cycle.
- No check when `sp`=0. Flag and `RX` changes between strobes are ignored.
- Back-to-back `sp` on consecutive cycles is legal; each strobe is one bit.
- Reset asserted mid-field: immediate return to reset values. After release, the first `sp` with the flag low counts as bit 0.

## Structure
- Package `can_form_pkg`:
  - field codes NONE=0, CRC_D=1, ACK_D=2, EOF=3, ERR_D=4;
  - FSM state enum;
  - default lengths 7 and 8.
- Sub-module `form_field_counter`: strobe-enabled, saturating bit counter with clear. It is instantiated once and shared by the EOF and DELIM states.

## Test plan
- CRC_D low, `RX`=0 on `sp` → `FORM_Error`=0 next cycle, `err_field`=1, `err_pos`=0, `err_count`=1; next `sp` with no flag → `FORM_Error`=1 (STICKY=0).
- ACK_D and CRC_D both low, `RX`=0 → `err_field`=2, `err_count` increments by one only.
- EOF with 7 recessive bits → no error. Repeat with bit 3 dominant → `err_field`=3, `err_pos`=3.
- RX_MODE=1, EOF bit 6 dominant → `overload_req` one-cycle pulse, `FORM_Error`=1. RX_MODE=0, same stimulus → error with `err_pos`=6.
- STICKY=1:
  - error at ERR_D bit 5 → `FORM_Error` stays 0 across 10 clean strobes;
  - `clear` → `FORM_Error`=1, `err_count`=0;
  - 300 errors with CNT_W=8 → `err_count`=255.
- Reset pulled low at EOF bit 4 → all outputs at reset values. After release, 7 recessive EOF bits → no error.

Source files
------------

// File: rtl/can_form_pkg.sv
// Shared types for the CAN form-error checker: field codes, FSM states,
// error report payload and the field priority decode.
package can_form_pkg;

  localparam int unsigned FIELD_W       = 3;
  localparam int unsigned POS_W         = 4;
  localparam int unsigned DEF_EOF_LEN   = 7;
  localparam int unsigned DEF_DELIM_LEN = 8;

  typedef enum logic [FIELD_W-1:0] {
    FLD_NONE  = 3'd0,
    FLD_CRC_D = 3'd1,
    FLD_ACK_D = 3'd2,
    FLD_EOF   = 3'd3,
    FLD_ERR_D = 3'd4
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EOF   = 2'd1,
    ST_DELIM = 2'd2
  } state_e;

  typedef struct packed {
    field_e           field;
    logic [POS_W-1:0] pos;
  } err_rpt_t;

  // Highest-priority active-low field flag wins: ACK_D > CRC_D > EOF > ERR_D.
  function automatic field_e select_field(input logic crc_n, input logic ack_n,
                                          input logic eof_n, input logic errd_n);
    if (!ack_n) begin
      return FLD_ACK_D;
    end else if (!crc_n) begin
      return FLD_CRC_D;
    end else if (!eof_n) begin
      return FLD_EOF;
    end else if (!errd_n) begin
      return FLD_ERR_D;
    end
    return FLD_NONE;
  endfunction

endpackage

// File: rtl/form_field_counter.sv
// Strobe-enabled saturating bit counter shared by the EOF and delimiter fields.
module form_field_counter
  import can_form_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             restart_i,
  input  logic [POS_W-1:0] limit_i,
  output logic [POS_W-1:0] cnt_o
);

  logic [POS_W-1:0] cnt_q;
  logic [POS_W-1:0] cnt_d;

  // Restart loads 1 because the strobe that restarts the field consumes bit 0.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (restart_i) begin
        cnt_d = POS_W'(1);
      end else if (cnt_q < limit_i) begin
        cnt_d = cnt_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/can_form_checker.sv
// CAN form-error checker: validates CRC/ACK delimiters, EOF and error/overload
// delimiter bits on each sample point and reports violations.
module can_form_checker
  import can_form_pkg::*;
#(
  parameter int unsigned EOF_LEN   = DEF_EOF_LEN,
  parameter int unsigned DELIM_LEN = DEF_DELIM_LEN,
  parameter bit          RX_MODE   = 1'b1,
  parameter bit          STICKY    = 1'b0,
  parameter int unsigned CNT_W     = 8
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               sp,
  input  logic               RX,
  input  logic               F_CRC_D,
  input  logic               F_ACK_D,
  input  logic               F_EOF,
  input  logic               F_ERR_D,
  input  logic               clear,
  output logic               FORM_Error,
  output logic [FIELD_W-1:0] err_field,
  output logic [POS_W-1:0]   err_pos,
  output logic               overload_req,
  output logic [CNT_W-1:0]   err_count
);

  localparam logic [POS_W-1:0] EOF_LIM   = POS_W'(EOF_LEN);
  localparam logic [POS_W-1:0] EOF_LAST  = POS_W'(EOF_LEN - 1);
  localparam logic [POS_W-1:0] DELIM_LIM = POS_W'(DELIM_LEN);

  state_e           state_q, state_d;
  err_rpt_t         rpt_q, rpt_d;
  logic             form_n_q, form_n_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  field_e           fld_c;
  logic [POS_W-1:0] bit_cnt;
  logic [POS_W-1:0] idx_c;
  logic [POS_W-1:0] cnt_lim_c;
  logic             err_c;
  logic             ovl_c;
  logic             cnt_en_c;
  logic             cnt_clr_c;
  logic             cnt_restart_c;

  assign fld_c = select_field(F_CRC_D, F_ACK_D, F_EOF, F_ERR_D);

  form_field_counter u_bit_cnt (
    .clk_i     (clock),
    .rst_ni    (reset),
    .en_i      (cnt_en_c),
    .clr_i     (cnt_clr_c),
    .restart_i (cnt_restart_c),
    .limit_i   (cnt_lim_c),
    .cnt_o     (bit_cnt)
  );

  // Field decode and bit check; single-bit delimiters leave the FSM untouched.
  always_comb begin
    state_d       = state_q;
    idx_c         = '0;
    err_c         = 1'b0;
    ovl_c         = 1'b0;
    cnt_en_c      = 1'b0;
    cnt_clr_c     = 1'b0;
    cnt_restart_c = 1'b0;
    cnt_lim_c     = EOF_LIM;
    if (sp) begin
      case (fld_c)
        FLD_CRC_D, FLD_ACK_D: begin
          err_c = ~RX;
        end
        FLD_EOF: begin
          cnt_en_c = 1'b1;
          state_d  = ST_EOF;
          if (state_q == ST_EOF) begin
            idx_c = bit_cnt;
          end else begin
            cnt_restart_c = 1'b1;
          end
          if (!RX && (idx_c < EOF_LIM)) begin
            if (RX_MODE && (idx_c == EOF_LAST)) begin
              ovl_c = 1'b1;
            end else begin
              err_c = 1'b1;
            end
          end
        end
        FLD_ERR_D: begin
          cnt_en_c  = 1'b1;
          cnt_lim_c = DELIM_LIM;
          state_d   = ST_DELIM;
          if (state_q == ST_DELIM) begin
            idx_c = bit_cnt;
          end else begin
            cnt_restart_c = 1'b1;
          end
          if (!RX && (idx_c < DELIM_LIM)) begin
            err_c = 1'b1;
          end
        end
        default: begin
          cnt_en_c  = 1'b1;
          cnt_clr_c = 1'b1;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  // Error reporting; an error on the same cycle as clear takes precedence.
  always_comb begin
    rpt_d = rpt_q;
    ovl_d = ovl_c;
    if (err_c) begin
      rpt_d.field = fld_c;
      rpt_d.pos   = idx_c;
    end
    if (STICKY) begin
      if (err_c) begin
        form_n_d = 1'b0;
      end else if (clear) begin
        form_n_d = 1'b1;
      end else begin
        form_n_d = form_n_q;
      end
    end else begin
      form_n_d = sp ? ~err_c : form_n_q;
    end
    if (clear) begin
      cnt_d = err_c ? CNT_W'(1) : '0;
    end else if (err_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rpt_q.field <= FLD_NONE;
      rpt_q.pos   <= '0;
      form_n_q    <= 1'b1;
      ovl_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q  <= state_d;
      rpt_q    <= rpt_d;
      form_n_q <= form_n_d;
      ovl_q    <= ovl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign FORM_Error   = form_n_q;
  assign err_field    = rpt_q.field;
  assign err_pos      = rpt_q.pos;
  assign overload_req = ovl_q;
  assign err_count    = cnt_q;

endmodule
